// File: rtl/ram_load_ctrl_pkg.sv
// Shared types for the RAM load controller.
// Per-channel fill state and fixed channel roles.
package ram_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } ch_state_e;

  localparam int CH_DATA   = 0;
  localparam int CH_WEIGHT = 1;

endpackage

// File: rtl/ram_load_ctrl_if.sv
// Input stream, length config and RAM write bus
// of the RAM load controller.
interface ram_load_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int DW     = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH),
  parameter int SW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);

  logic [SW-1:0]     sel;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              cfg_we;
  logic [SW-1:0]     cfg_ch;
  logic [AW:0]       cfg_len;
  logic              clear;
  logic [NUM_CH-1:0] wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NUM_CH-1:0] full;
  logic              all_full;
  logic              done;
  logic              err;

  modport master (
    output sel, in_valid, in_data,
    output cfg_we, cfg_ch, cfg_len, clear,
    input  in_ready, wr_en, wr_addr, wr_data,
    input  full, all_full, done, err
  );

  modport slave (
    input  sel, in_valid, in_data,
    input  cfg_we, cfg_ch, cfg_len, clear,
    output in_ready, wr_en, wr_addr, wr_data,
    output full, all_full, done, err
  );

endinterface

// File: rtl/ram_load_ctrl_fill_counter.sv
// One channel's fill counter: cnt, len and
// EMPTY/FILLING/FULL state.
module ram_fill_counter
  import ram_load_ctrl_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_inc,
  input  logic        i_cfg_we,
  input  logic [AW:0] i_cfg_len,
  output logic [AW-1:0] o_cnt,
  output logic        o_full,
  output ch_state_e   o_state
);

  ch_state_e     r_state, w_state_n;
  logic [AW-1:0] r_cnt, w_cnt_n;
  logic [AW:0]   r_len, w_len_n;
  logic          w_last;

  assign w_last = ({1'b0, r_cnt} == r_len - (AW+1)'(1));

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_len_n   = r_len;
    if (i_clear) begin
      w_state_n = ST_EMPTY;
      w_cnt_n   = '0;
    end else if (i_inc) begin
      // cnt stays at len-1 once full
      if (w_last) begin
        w_state_n = ST_FULL;
      end else begin
        w_state_n = ST_FILLING;
        w_cnt_n   = r_cnt + AW'(1);
      end
    end
    if (i_cfg_we) w_len_n = i_cfg_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
      r_len   <= (AW+1)'(DEPTH);
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_len   <= w_len_n;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_full  = (r_state == ST_FULL);
  assign o_state = r_state;

endmodule

// File: rtl/ram_load_ctrl.sv
// Routes an input stream into per-channel RAMs,
// tracking fill level, completion and misuse.
module ram_load_ctrl
  import ram_load_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DW     = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  ram_load_ctrl_if.slave  bus
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] w_full;
  logic [AW-1:0]     w_cnt   [NUM_CH];
  ch_state_e         w_state [NUM_CH];

  logic w_sel_ok, w_ready, w_accept, w_drop;
  logic w_ch_ok, w_len_ok, w_ch_empty;
  logic w_cfg_ok, w_cfg_bad, w_all_full;

  assign w_sel_ok = (32'(bus.sel) < NUM_CH);
  assign w_ready  = w_sel_ok && !w_full[bus.sel];
  assign w_accept = bus.in_valid & w_ready & ~bus.clear;
  assign w_drop   = bus.in_valid & ~w_ready;

  assign w_ch_ok  = (32'(bus.cfg_ch) < NUM_CH);
  assign w_len_ok = (bus.cfg_len != '0) &&
                    (bus.cfg_len <= (AW+1)'(DEPTH));
  // a clearing channel counts as EMPTY for config
  assign w_ch_empty = bus.clear ||
                      (w_state[bus.cfg_ch] == ST_EMPTY);
  assign w_cfg_ok  = bus.cfg_we & w_ch_ok &
                     w_len_ok & w_ch_empty;
  assign w_cfg_bad = bus.cfg_we & ~w_cfg_ok;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ram_fill_counter #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (bus.clear),
      .i_inc     (w_accept && (bus.sel == SW'(c))),
      .i_cfg_we  (w_cfg_ok && (bus.cfg_ch == SW'(c))),
      .i_cfg_len (bus.cfg_len),
      .o_cnt     (w_cnt[c]),
      .o_full    (w_full[c]),
      .o_state   (w_state[c])
    );
  end

  logic [NUM_CH-1:0] r_wr_en;
  logic [AW-1:0]     r_wr_addr;
  logic [DW-1:0]     r_wr_data;
  logic              r_err;
  logic              r_all_full_d;

  assign w_all_full = &w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en      <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_err        <= 1'b0;
      r_all_full_d <= 1'b0;
    end else begin
      r_wr_en      <= w_accept ?
                      (NUM_CH'(1) << bus.sel) : '0;
      r_all_full_d <= w_all_full;
      if (w_accept) begin
        r_wr_addr <= w_cnt[bus.sel];
        r_wr_data <= bus.in_data;
      end
      if (bus.clear)
        r_err <= 1'b0;
      else if (w_drop || w_cfg_bad)
        r_err <= 1'b1;
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.full     = w_full;
  assign bus.all_full = w_all_full;
  assign bus.done     = w_all_full & ~r_all_full_d;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_ram_load_ctrl.sv
// Directed vector table plus long-stream
// sequences for ram_load_ctrl.
module tb_ram_load_ctrl;
  import ram_load_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_load_ctrl_if #(
    .NUM_CH(2), .DW(8), .DEPTH(64)
  ) u_if ();

  ram_load_ctrl #(
    .NUM_CH(2), .DW(8), .DEPTH(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  typedef struct {
    logic       sel;
    logic       vld;
    logic [7:0] din;
    logic       cwe;
    logic       cch;
    logic [6:0] clen;
    logic       clr;
    logic [1:0] e_wen;
    logic [5:0] e_addr;
    logic [7:0] e_data;
    logic [1:0] e_full;
    logic       e_all;
    logic       e_done;
    logic       e_err;
    logic       e_rdy;
  } vec_t;

  vec_t vt [20];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(logic s, logic v,
                       logic [7:0] d, logic cwe,
                       logic cch, logic [6:0] cl,
                       logic clr);
    u_if.sel      = s;
    u_if.in_valid = v;
    u_if.in_data  = d;
    u_if.cfg_we   = cwe;
    u_if.cfg_ch   = cch;
    u_if.cfg_len  = cl;
    u_if.clear    = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 0, 0, 7'd0, 0);
  endtask

  task automatic do_rst();
    idle();
    rst = 1'b1;
    step();
    chk("rst_wen", u_if.wr_en, 0);
    chk("rst_addr", u_if.wr_addr, 0);
    chk("rst_data", u_if.wr_data, 0);
    chk("rst_full", u_if.full, 0);
    chk("rst_all", u_if.all_full, 0);
    chk("rst_done", u_if.done, 0);
    chk("rst_err", u_if.err, 0);
    rst = 1'b0;
  endtask

  task automatic push(logic s, logic [7:0] d,
                      logic [1:0] e_wen,
                      logic [5:0] e_addr);
    drive(s, 1, d, 0, 0, 7'd0, 0);
    step();
    chk("push_wen", u_if.wr_en, e_wen);
    chk("push_addr", u_if.wr_addr, e_addr);
    chk("push_data", u_if.wr_data, d);
  endtask

  initial begin
    vt[0]  = '{0,0,8'h00,0,0,7'd0,0, 0,0,8'h00,0,0,0,0,1};
    vt[1]  = '{0,0,8'h00,1,0,7'd3,0, 0,0,8'h00,0,0,0,0,1};
    vt[2]  = '{0,0,8'h00,1,1,7'd2,0, 0,0,8'h00,0,0,0,0,1};
    vt[3]  = '{0,1,8'hA1,0,0,7'd0,0, 1,0,8'hA1,0,0,0,0,1};
    vt[4]  = '{0,0,8'h00,1,0,7'd5,0, 0,0,8'h00,0,0,0,1,1};
    vt[5]  = '{0,1,8'hB2,0,0,7'd0,0, 1,1,8'hB2,0,0,0,1,1};
    vt[6]  = '{0,1,8'hC3,0,0,7'd0,0, 1,2,8'hC3,1,0,0,1,0};
    vt[7]  = '{0,1,8'hD4,0,0,7'd0,0, 0,0,8'h00,1,0,0,1,0};
    vt[8]  = '{1,1,8'hE5,0,0,7'd0,0, 2,0,8'hE5,1,0,0,1,1};
    vt[9]  = '{1,1,8'hF6,0,0,7'd0,0, 2,1,8'hF6,3,1,1,1,0};
    vt[10] = '{1,0,8'h00,0,0,7'd0,0, 0,0,8'h00,3,1,0,1,0};
    vt[11] = '{0,1,8'h11,1,0,7'd1,1, 0,0,8'h00,0,0,0,0,1};
    vt[12] = '{0,1,8'h77,0,0,7'd0,0, 1,0,8'h77,1,0,0,0,0};
    vt[13] = '{1,1,8'h88,0,0,7'd0,0, 2,0,8'h88,1,0,0,0,1};
    vt[14] = '{1,1,8'h99,0,0,7'd0,0, 2,1,8'h99,3,1,1,0,0};
    vt[15] = '{0,0,8'h00,0,0,7'd0,1, 0,0,8'h00,0,0,0,0,1};
    vt[16] = '{0,0,8'h00,1,1,7'd0,0, 0,0,8'h00,0,0,0,1,1};
    vt[17] = '{0,0,8'h00,0,0,7'd0,1, 0,0,8'h00,0,0,0,0,1};
    vt[18] = '{0,0,8'h00,1,0,7'd65,0,0,0,8'h00,0,0,0,1,1};
    vt[19] = '{0,0,8'h00,1,1,7'd6,0, 0,0,8'h00,0,0,0,1,1};

    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      if (i > 0)
        drive(vt[i].sel, vt[i].vld, vt[i].din,
              vt[i].cwe, vt[i].cch, vt[i].clen,
              vt[i].clr);
      else
        idle();
      step();
      chk($sformatf("v%0d_wen", i),
          u_if.wr_en, vt[i].e_wen);
      if (i == 0 || vt[i].e_wen != 0) begin
        chk($sformatf("v%0d_addr", i),
            u_if.wr_addr, vt[i].e_addr);
        chk($sformatf("v%0d_data", i),
            u_if.wr_data, vt[i].e_data);
      end
      chk($sformatf("v%0d_full", i),
          u_if.full, vt[i].e_full);
      chk($sformatf("v%0d_all", i),
          u_if.all_full, vt[i].e_all);
      chk($sformatf("v%0d_done", i),
          u_if.done, vt[i].e_done);
      chk($sformatf("v%0d_err", i),
          u_if.err, vt[i].e_err);
      chk($sformatf("v%0d_rdy", i),
          u_if.in_ready, vt[i].e_rdy);
    end

    // 64 words fill channel 0 at default length
    do_rst();
    for (int i = 0; i < 64; i++) begin
      push(0, 8'(i) ^ 8'h5A, 2'b01, 6'(i));
      chk("fill0_full", u_if.full[0], (i == 63));
    end
    chk("fill0_rdy", u_if.in_ready, 0);

    // channel 1 at length 54, done pulses once
    drive(0, 0, 8'h00, 1, 1, 7'd54, 0);
    step();
    chk("cfg54_err", u_if.err, 0);
    for (int i = 0; i < 54; i++) begin
      push(1, 8'(i + 3), 2'b10, 6'(i));
      chk("fill1_full", u_if.full[1], (i == 53));
    end
    chk("fill1_all", u_if.all_full, 1);
    chk("fill1_done", u_if.done, 1);
    idle();
    step();
    chk("done_once", u_if.done, 0);
    chk("all_hold", u_if.all_full, 1);

    // 65th word to channel 0 is dropped
    drive(0, 1, 8'hFF, 0, 0, 7'd0, 0);
    step();
    chk("ovf_wen", u_if.wr_en, 0);
    chk("ovf_err", u_if.err, 1);
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("err_sticky", u_if.err, 1);
    end
    drive(0, 0, 8'h00, 0, 0, 7'd0, 1);
    step();
    chk("clr_err", u_if.err, 0);
    chk("clr_full", u_if.full, 0);
    chk("clr_done", u_if.done, 0);

    // clear wins over a same-cycle accept
    for (int i = 0; i < 10; i++)
      push(0, 8'(i), 2'b01, 6'(i));
    drive(0, 1, 8'hEE, 0, 0, 7'd0, 1);
    step();
    chk("clracc_wen", u_if.wr_en, 0);
    chk("clracc_err", u_if.err, 0);
    push(0, 8'h42, 2'b01, 6'd0);
    for (int i = 0; i < 54; i++) begin
      push(1, 8'(i), 2'b10, 6'(i));
      chk("len1_kept", u_if.full[1], (i == 53));
    end

    // reset mid-fill restores default length
    drive(0, 0, 8'h00, 0, 0, 7'd0, 1);
    step();
    drive(0, 0, 8'h00, 1, 1, 7'd5, 0);
    step();
    chk("cfg5_err", u_if.err, 0);
    for (int i = 0; i < 3; i++)
      push(1, 8'(i), 2'b10, 6'(i));
    do_rst();
    chk("rst_rdy", u_if.in_ready, 1);
    for (int i = 0; i < 64; i++) begin
      push(1, 8'(i), 2'b10, 6'(i));
      if (i == 4)
        chk("len1_rst5", u_if.full[1], 0);
    end
    chk("len1_rst64", u_if.full[1], 1);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
